// File: rtl/vga_text_renderer.sv
// 80x30 text-mode renderer: character buffer + external font ROM -> 12-bit RGB through three
// p_tick stages, with hsync/vsync/video_on delayed to stay aligned with the pixel data.
module vga_text_renderer #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter int unsigned BLINK_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_on_out
);
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CNT_W  = 8;
    localparam logic [7:0]  SPACE  = 8'h20;

    logic [7:0]        char_mem [CELLS];
    logic [ADDR_W-1:0] rd_addr_c;
    logic [7:0]        rd_code;

    logic [6:0]        s1_col;
    logic [4:0]        s1_row;
    logic [3:0]        s1_glyph;
    logic [2:0]        s1_bit;
    logic              s1_von, s1_hs, s1_vs;

    logic [2:0]        s2_bit;
    logic              s2_hit, s2_von, s2_hs, s2_vs;

    logic [CNT_W-1:0]  frame_cnt;
    logic              vs_prev;

    logic              cursor_hit_c;
    logic              pix_c;
    logic [11:0]       rgb_c;
    logic              y_msb_unused;

    assign y_msb_unused = y[9];

    // row*80 + col from the raw position; the read is issued on the S1 tick
    assign rd_addr_c = ADDR_W'({y[8:4], 6'b0}) + ADDR_W'({y[8:4], 4'b0}) + ADDR_W'(x[9:3]);

    // Cells hold code XOR 0x20 so zero-initialised storage reads back as space
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < ADDR_W'(CELLS)))
            char_mem[wr_addr] <= wr_data ^ SPACE;
        if (p_tick)
            rd_code <= char_mem[rd_addr_c] ^ SPACE;
    end

    always_comb begin
        cursor_hit_c = 1'b0;
        pix_c        = 1'b0;
        rgb_c        = '0;
        cursor_hit_c = cursor_en && (cursor_col < 7'(COLS)) && (cursor_row < 5'(ROWS)) &&
                       (s1_col == cursor_col) && (s1_row == cursor_row);
        pix_c        = font_data[~s2_bit] ^ (s2_hit & ~frame_cnt[BLINK_BIT]);
        rgb_c        = s2_von ? (pix_c ? FG_COLOR : BG_COLOR) : 12'h000;
    end

    // Three-stage pixel pipeline, advanced only on p_tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_col       <= '0;
            s1_row       <= '0;
            s1_glyph     <= '0;
            s1_bit       <= '0;
            s1_von       <= 1'b0;
            s1_hs        <= 1'b1;
            s1_vs        <= 1'b1;
            font_addr    <= '0;
            s2_bit       <= '0;
            s2_hit       <= 1'b0;
            s2_von       <= 1'b0;
            s2_hs        <= 1'b1;
            s2_vs        <= 1'b1;
            rgb          <= '0;
            hsync_out    <= 1'b1;
            vsync_out    <= 1'b1;
            video_on_out <= 1'b0;
        end else if (p_tick) begin
            s1_col       <= x[9:3];
            s1_row       <= y[8:4];
            s1_glyph     <= y[3:0];
            s1_bit       <= x[2:0];
            s1_von       <= video_on;
            s1_hs        <= hsync_in;
            s1_vs        <= vsync_in;
            font_addr    <= {rd_code, s1_glyph};
            s2_bit       <= s1_bit;
            s2_hit       <= cursor_hit_c;
            s2_von       <= s1_von;
            s2_hs        <= s1_hs;
            s2_vs        <= s1_vs;
            rgb          <= rgb_c;
            hsync_out    <= s2_hs;
            vsync_out    <= s2_vs;
            video_on_out <= s2_von;
        end
    end

    // Frame counter for cursor blink: counts vsync falling edges seen on pixel ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            vs_prev   <= 1'b1;
        end else if (p_tick) begin
            vs_prev <= vsync_in;
            if (vs_prev && !vsync_in)
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench for vga_text_renderer: randomised pixel stream against a screen-level model.
module tb_vga_text_renderer;
    localparam int          COLS      = 80;
    localparam int          ROWS      = 30;
    localparam int          CELLS     = COLS * ROWS;
    localparam int          BLINK_BIT = 4;
    localparam logic [11:0] FG        = 12'hFFF;
    localparam logic [11:0] BG        = 12'h000;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        von;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        video_on_out;

    int          checks = 0;
    int          failures = 0;
    int          tick_no = 0;

    exp_t        exp_q[$];
    logic [7:0]  mem_m [CELLS];
    int          frame_m;
    bit          prev_vs_m;
    bit          rand_wr = 0;
    bit          force_wr = 0;
    int          f_addr, f_data;
    bit          nx_en = 0;
    int          nx_col = 0, nx_row = 0;

    vga_text_renderer #(
        .COLS(COLS), .ROWS(ROWS), .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_BIT(BLINK_BIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .font_addr(font_addr), .font_data(font_data),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        logic [11:0] h;
        if (a[11:4] == 8'h20) return 8'h00;
        if (a[11:4] == 8'h41) return 8'h81;
        h = (a * 12'd37) ^ (a >> 3);
        return h[7:0];
    endfunction

    // External synchronous font ROM
    always @(posedge clk) font_data <= rom_f(font_addr);

    // What the screen should show for one sampled position
    function automatic exp_t model_px(input int px, input int py, input bit von,
                                      input bit hs, input bit vs);
        exp_t       r;
        int         col, row;
        logic [7:0] code, glyph;
        bit         pix;
        col   = px / 8;
        row   = py / 16;
        code  = (row * COLS + col < CELLS) ? mem_m[row * COLS + col] : 8'h00;
        glyph = rom_f({code, 4'(py % 16)});
        pix   = glyph[7 - (px % 8)];
        if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) &&
            ((frame_m >> BLINK_BIT) & 1) == 0)
            pix = !pix;
        r.rgb = von ? (pix ? FG : BG) : 12'h000;
        r.hs  = hs;
        r.vs  = vs;
        r.von = von;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            failures++;
            $display("FAIL %s got=%0h need=%0h", name, got, need);
        end
    endtask

    // One clk of stimulus, entered and left at posedge+1
    task automatic cycle(input bit tick, input int px, input int py, input bit von,
                         input bit hs, input bit vs);
        bit we;
        int wa, wd;
        we = 0; wa = 0; wd = 0;
        if (rand_wr && $urandom_range(0, 7) == 0) begin
            we = 1;
            wa = int'($urandom_range(0, CELLS + 99));
            wd = int'($urandom_range(0, 255));
        end
        if (force_wr) begin
            we = 1; wa = f_addr; wd = f_data; force_wr = 0;
        end
        p_tick = tick; x = 10'(px); y = 10'(py); video_on = von;
        hsync_in = hs; vsync_in = vs;
        wr_en = we; wr_addr = 12'(wa); wr_data = 8'(wd);
        if (tick) begin
            if (prev_vs_m && !vs) frame_m = (frame_m + 1) % 256;
            prev_vs_m = vs;
            exp_q.push_back(model_px(px, py, von, hs, vs));
        end
        if (we && wa < CELLS) mem_m[wa] = 8'(wd);
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py, input bit von, input bit hs, input bit vs);
        cycle(1, px, py, von, hs, vs);
        repeat ($urandom_range(1, 2)) cycle(0, px, py, von, hs, vs);
    endtask

    task automatic write_cell(input int a, input int d);
        force_wr = 1; f_addr = a; f_data = d;
        cycle(0, 0, 0, 0, 1, 1);
    endtask

    // Vertical blanking: cursor changes land well away from visible pixels
    task automatic blank();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                cursor_en = nx_en; cursor_col = 7'(nx_col); cursor_row = 5'(nx_row);
            end
            pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 0,
                bit'($urandom_range(0, 1)), (i == 5 || i == 6) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic rand_frame(input int n);
        for (int i = 0; i < n; i++)
            pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                $urandom_range(0, 7) != 0, bit'($urandom_range(0, 1)), 1);
        nx_en  = bit'($urandom_range(0, 1));
        nx_col = int'($urandom_range(0, 90));
        nx_row = int'($urandom_range(0, 31));
        blank();
    endtask

    task automatic cursor_frame(input int n);
        for (int i = 0; i < n; i++)
            pix(int'($urandom_range(36, 51)), int'($urandom_range(28, 51)), 1,
                bit'($urandom_range(0, 1)), 1);
        blank();
    endtask

    task automatic do_reset();
        p_tick = 0; wr_en = 0;
        rst_n = 0;
        #1;
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_hsync", int'(hsync_out), 1);
        chk("reset_vsync", int'(vsync_out), 1);
        chk("reset_video_on", int'(video_on_out), 0);
        exp_q.delete();
        repeat (3) exp_q.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1, von: 1'b0});
        frame_m = 0;
        prev_vs_m = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one output sample per pixel tick, taken mid-cycle
    always @(negedge clk) begin : monitor
        exp_t e, got;
        if (rst_n && p_tick) begin
            tick_no++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty tick=%0d", tick_no);
            end else begin
                e   = exp_q.pop_front();
                got = {rgb, hsync_out, vsync_out, video_on_out};
                if (got !== e) begin
                    failures++;
                    $display("FAIL pixel tick=%0d got rgb=%h hs=%b vs=%b von=%b need rgb=%h hs=%b vs=%b von=%b",
                             tick_no, got.rgb, got.hs, got.vs, got.von, e.rgb, e.hs, e.vs, e.von);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < CELLS; i++) mem_m[i] = 8'h20;
        frame_m = 0;
        prev_vs_m = 1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Blank screen: syncs and video_on delayed by three ticks, rgb dark
        repeat (3) rand_frame(30);

        // Cell 81 = 'A' renders edge columns at x=8 and x=15 for y=16..31
        write_cell(81, 8'h41);
        for (int yy = 16; yy < 32; yy++)
            for (int xx = 7; xx < 17; xx++)
                pix(xx, yy, 1, 1, 1);
        blank();

        // Out-of-range write leaves cell 0 blank
        write_cell(CELLS, 8'h41);
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 8; xx++)
                pix(xx, yy, 1, 1, 1);
        blank();

        // Write cell 0 on the very tick its read is issued: old code this pass, new next frame
        force_wr = 1; f_addr = 0; f_data = 8'h41;
        pix(0, 0, 1, 1, 1);
        pix(7, 0, 1, 1, 1);
        blank();
        pix(0, 0, 1, 1, 1);
        pix(3, 0, 1, 1, 1);
        pix(7, 0, 1, 1, 1);
        blank();

        // Blinking cursor at (5,2) from a fresh frame count
        cursor_en = 1; cursor_col = 7'd5; cursor_row = 5'd2;
        nx_en = 1; nx_col = 5; nx_row = 2;
        do_reset();
        for (int f = 0; f < 34; f++) cursor_frame(12);

        // Random traffic with writes and random cursor placement (incl. outside the grid)
        rand_wr = 1;
        for (int f = 0; f < 16; f++) rand_frame(40);
        rand_wr = 0;

        // Reset in the middle of a lit region
        write_cell(12 * COLS + 37, 8'h41);
        repeat (3) pix(296, 200, 1, 0, 1);
        pix(300, 200, 1, 0, 1);
        cursor_en = 1; cursor_col = 7'd5; cursor_row = 5'd2;
        nx_en = 1; nx_col = 5; nx_row = 2;
        do_reset();
        repeat (2) cursor_frame(12);
        rand_frame(30);
        repeat (4) pix(0, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
